// File: rtl/uart_tx_frame.sv
// UART transmitter: one frame per accepted word (start, LSB-first data, optional parity, stop bits).
// Start bit goes out one edge after data_valid; requests that arrive while busy are dropped, not queued.
module uart_tx_frame #(
  parameter int data_width = 8,
  parameter int pre_scalar = 8,
  parameter int stop_bits  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int PW = (pre_scalar > 1) ? $clog2(pre_scalar) : 1;
  localparam int BW = (data_width > 2) ? $clog2(data_width) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(pre_scalar - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(data_width - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(stop_bits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         pre_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [data_width-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  pre_tc;
  logic [PW-1:0]         pre_cnt_d;
  logic [BW-1:0]         bit_cnt_d;
  logic                  par_bit_d;

  // Parity always comes from the captured word, never from live p_data.
  always_comb begin
    pre_tc    = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = pre_tc ? '0 : pre_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q + 1'b1;
    par_bit_d = (^data_q) ^ par_typ_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pre_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (data_valid) begin
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end
        end
        S_START: begin
          pre_cnt_q <= pre_cnt_d;
          if (pre_tc) begin
            bit_cnt_q <= '0;
            tx_q      <= data_q[0];
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          pre_cnt_q <= pre_cnt_d;
          if (pre_tc) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_d;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_d;
              tx_q      <= data_q[bit_cnt_d];
            end
          end
        end
        S_PARITY: begin
          pre_cnt_q <= pre_cnt_d;
          if (pre_tc) begin
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          pre_cnt_q <= pre_cnt_d;
          if (pre_tc) begin
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: default build, a two-stop-bit build and a one-clock-per-bit build.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_typ;
  logic       dv0, dv1, dv2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  int         total;
  int         bad;

  uart_tx_frame u_dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv0),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx0), .busy(busy0)
  );

  uart_tx_frame #(.stop_bits(2)) u_dut_stop2 (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv1),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx1), .busy(busy1)
  );

  uart_tx_frame #(.pre_scalar(1)) u_dut_fast (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv2),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cur_tx(input int which);
    case (which)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic cur_busy(input int which);
    case (which)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_dv(input int which, input logic v);
    case (which)
      0:       dv0 = v;
      1:       dv1 = v;
      default: dv2 = v;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // exp_bits[s] is the line level for slot s; mid_act 1 pulses a 0xFF request
  // mid-frame, mid_act 2 flips p_data/par_en/par_typ mid-frame.
  task automatic run_frame(input string tag, input int which, input logic [7:0] d,
                           input logic pe, input logic pt, input logic [11:0] exp_bits,
                           input int nslots, input int p);
    run_frame_x(tag, which, d, pe, pt, exp_bits, nslots, p, 0);
  endtask

  task automatic run_frame_x(input string tag, input int which, input logic [7:0] d,
                             input logic pe, input logic pt, input logic [11:0] exp_bits,
                             input int nslots, input int p, input int mid_act);
    int busy_cnt;
    int match_cnt;
    p_data  = d;
    par_en  = pe;
    par_typ = pt;
    set_dv(which, 1'b1);
    @(negedge clk);
    set_dv(which, 1'b0);
    busy_cnt = 0;
    for (int s = 0; s < nslots; s++) begin
      match_cnt = 0;
      for (int c = 0; c < p; c++) begin
        if (cur_tx(which) === exp_bits[s]) match_cnt++;
        if (cur_busy(which) === 1'b1) busy_cnt++;
        if (mid_act == 1 && s == 4 && c == 2) begin
          dv0    = 1'b1;
          p_data = 8'hFF;
        end
        if (mid_act == 1 && s == 4 && c == 3) dv0 = 1'b0;
        if (mid_act == 2 && s == 3 && c == 1) begin
          p_data  = ~d;
          par_en  = ~pe;
          par_typ = ~pt;
        end
        @(negedge clk);
      end
      check($sformatf("%s_slot%0d", tag, s), match_cnt, p);
    end
    for (int k = 0; k < 8; k++) begin
      if (cur_busy(which) !== 1'b1) break;
      busy_cnt++;
      @(negedge clk);
    end
    check($sformatf("%s_busy_cycles", tag), busy_cnt, nslots * p);
    check($sformatf("%s_idle_tx", tag), cur_tx(which), 1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    dv0     = 1'b1;
    dv1     = 1'b1;
    dv2     = 1'b1;
    p_data  = 8'hFF;
    par_en  = 1'b1;
    par_typ = 1'b0;

    // Reset held with data_valid asserted: nothing may start.
    repeat (2) begin
      @(negedge clk);
      check("rst_tx", tx0, 1);
      check("rst_busy", busy0, 0);
    end
    rst = 1'b0;
    dv0 = 1'b0;
    dv1 = 1'b0;
    dv2 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_tx", tx0, 1);
      check("post_rst_busy", busy0, 0);
      check("post_rst_busy_stop2", busy1, 0);
      check("post_rst_busy_fast", busy2, 0);
    end

    run_frame("even_a5", 0, 8'hA5, 1'b1, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8);
    run_frame("odd_a5", 0, 8'hA5, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 8);
    run_frame("nopar_3c", 0, 8'h3C, 1'b0, 1'b0, {2'b01, 8'h3C, 1'b0}, 10, 8);
    run_frame("stop2_3c", 1, 8'h3C, 1'b0, 1'b0, {2'b11, 8'h3C, 1'b0}, 11, 8);

    // Request while busy is dropped; 0x81 goes out on the first idle edge.
    run_frame_x("zero_req_ff", 0, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h00, 1'b0}, 11, 8, 1);
    run_frame("back_81", 0, 8'h81, 1'b1, 1'b0, {1'b1, 1'b0, 8'h81, 1'b0}, 11, 8);

    run_frame_x("mid_chg_96", 0, 8'h96, 1'b1, 1'b0, {1'b1, 1'b0, 8'h96, 1'b0}, 11, 8, 2);

    // Reset in the middle of data bit 3 of a 0xF0 frame.
    p_data  = 8'hF0;
    par_en  = 1'b1;
    par_typ = 1'b0;
    dv0     = 1'b1;
    @(negedge clk);
    dv0 = 1'b0;
    repeat (34) @(negedge clk);
    check("f0_bit3_tx", tx0, 0);
    check("f0_bit3_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx0, 1);
    check("midrst_busy", busy0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_tx", tx0, 1);
    check("after_rst_busy", busy0, 0);
    run_frame("after_rst_55", 0, 8'h55, 1'b1, 1'b0, {1'b1, 1'b0, 8'h55, 1'b0}, 11, 8);

    run_frame("fast_01", 2, 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
